// File: rtl/switch_toggle_bank.sv
// Multi-channel switch front end: per-channel 2-flop synchroniser, debouncer,
// qualified edge detector and LED toggle, plus a shared wrapping event counter.
module switch_toggle_bank #(
  parameter int NUM_CH         = 4,
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int EDGE_MODE      = 0,
  parameter int COUNT_WIDTH    = 8
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic [NUM_CH-1:0]      i_Switch,
  input  logic                   i_Clear,
  output logic [NUM_CH-1:0]      o_LED,
  output logic [NUM_CH-1:0]      o_Edge_Pulse,
  output logic [COUNT_WIDTH-1:0] o_Event_Count
);

  localparam int CNT_W = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_LIMIT - 1);

  logic [NUM_CH-1:0]      sync_meta;
  logic [NUM_CH-1:0]      sync_level;
  logic [NUM_CH-1:0]      stable;
  logic [NUM_CH-1:0]      stable_prev;
  logic [NUM_CH-1:0]      qual_edge;
  logic [COUNT_WIDTH-1:0] edge_total;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      sync_meta  <= '0;
      sync_level <= '0;
    end else begin
      sync_meta  <= i_Switch;
      sync_level <= sync_meta;
    end
  end

  // A new level is accepted only after it has been seen DEBOUNCE_LIMIT
  // consecutive cycles; any return to the stable level restarts the count.
  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_channel
    logic [CNT_W-1:0] db_count;
    logic             stable_q;

    always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
        db_count <= '0;
        stable_q <= 1'b0;
      end else if (sync_level[ch] == stable_q) begin
        db_count <= '0;
      end else if (db_count == LAST_CNT) begin
        stable_q <= sync_level[ch];
        db_count <= '0;
      end else begin
        db_count <= db_count + 1'b1;
      end
    end

    assign stable[ch] = stable_q;
  end

  always_comb begin
    qual_edge = '0;
    case (EDGE_MODE)
      1:       qual_edge = stable & ~stable_prev;
      2:       qual_edge = stable ^ stable_prev;
      default: qual_edge = ~stable & stable_prev;
    endcase
  end

  always_comb begin
    edge_total = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      edge_total = edge_total + COUNT_WIDTH'(qual_edge[n]);
    end
  end

  // Clear wins over a coincident toggle but leaves pulses and counting alone.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      stable_prev   <= '0;
      o_Edge_Pulse  <= '0;
      o_LED         <= '0;
      o_Event_Count <= '0;
    end else begin
      stable_prev   <= stable;
      o_Edge_Pulse  <= qual_edge;
      o_LED         <= i_Clear ? '0 : (o_LED ^ qual_edge);
      o_Event_Count <= o_Event_Count + edge_total;
    end
  end

endmodule

// File: tb/tb_switch_toggle_bank.sv
// Directed bench for switch_toggle_bank: a falling-edge instance and a
// both-edges instance, each with NUM_CH=4, DEBOUNCE_LIMIT=4, COUNT_WIDTH=4.
module tb_switch_toggle_bank;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  logic       rst0, clr0, rst2, clr2;
  logic [3:0] sw0, led0, pulse0, cnt0;
  logic [3:0] sw2, led2, pulse2, cnt2;

  switch_toggle_bank #(.NUM_CH(4), .DEBOUNCE_LIMIT(4), .EDGE_MODE(0), .COUNT_WIDTH(4)) dut_fall (
    .i_Clk(clk), .i_Reset(rst0), .i_Switch(sw0), .i_Clear(clr0),
    .o_LED(led0), .o_Edge_Pulse(pulse0), .o_Event_Count(cnt0));

  switch_toggle_bank #(.NUM_CH(4), .DEBOUNCE_LIMIT(4), .EDGE_MODE(2), .COUNT_WIDTH(4)) dut_both (
    .i_Clk(clk), .i_Reset(rst2), .i_Switch(sw2), .i_Clear(clr2),
    .o_LED(led2), .o_Edge_Pulse(pulse2), .o_Event_Count(cnt2));

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst0 = 1'b1; rst2 = 1'b1; clr0 = 1'b0; clr2 = 1'b0;
    sw0 = 4'hF; sw2 = 4'h0;
    tick(3);
    checks++; if (led0 !== 4'h0) begin fails++; $display("[TB] FAIL reset_led got=%h exp=0", led0); end
    checks++; if (pulse0 !== 4'h0) begin fails++; $display("[TB] FAIL reset_pulse got=%h exp=0", pulse0); end
    checks++; if (cnt0 !== 4'h0) begin fails++; $display("[TB] FAIL reset_count got=%h exp=0", cnt0); end
    checks++; if (cnt2 !== 4'h0) begin fails++; $display("[TB] FAIL reset_count_both got=%h exp=0", cnt2); end
    rst0 = 1'b0; rst2 = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick(1);
      checks++; if (pulse0 !== 4'h0) begin fails++; $display("[TB] FAIL reset_no_rise_pulse cyc=%0d got=%h exp=0", c, pulse0); end
    end
    checks++; if (cnt0 !== 4'h0) begin fails++; $display("[TB] FAIL reset_rise_count got=%h exp=0", cnt0); end
  endtask

  task automatic test_falling_toggle;
    logic [3:0] exp_pulse;
    tick(12);
    sw0 = 4'hE;
    for (int e = 0; e < 10; e++) begin
      tick(1);
      exp_pulse = (e == 6) ? 4'b0001 : 4'b0000;
      checks++; if (pulse0 !== exp_pulse) begin fails++; $display("[TB] FAIL fall_pulse edge=%0d got=%h exp=%h", e, pulse0, exp_pulse); end
      if (e == 6) begin
        checks++; if (led0 !== 4'b0001) begin fails++; $display("[TB] FAIL fall_led got=%h exp=1", led0); end
        checks++; if (cnt0 !== 4'd1) begin fails++; $display("[TB] FAIL fall_count got=%0d exp=1", cnt0); end
      end
    end
    sw0 = 4'hF; tick(10);
    sw0 = 4'hE; tick(10);
    checks++; if (led0 !== 4'h0) begin fails++; $display("[TB] FAIL second_press_led got=%h exp=0", led0); end
    checks++; if (cnt0 !== 4'd2) begin fails++; $display("[TB] FAIL second_press_count got=%0d exp=2", cnt0); end
  endtask

  task automatic test_bounce;
    int pulses;
    sw0 = 4'b1100; tick(3);
    sw0 = 4'b1110;
    for (int c = 0; c < 12; c++) begin
      tick(1);
      checks++; if (pulse0 !== 4'h0) begin fails++; $display("[TB] FAIL bounce3_pulse cyc=%0d got=%h exp=0", c, pulse0); end
    end
    checks++; if (led0 !== 4'h0) begin fails++; $display("[TB] FAIL bounce3_led got=%h exp=0", led0); end
    pulses = 0;
    sw0 = 4'b1100; tick(4);
    sw0 = 4'b1110;
    for (int c = 0; c < 16; c++) begin
      tick(1);
      if (pulse0[1]) pulses++;
    end
    checks++; if (pulses !== 1) begin fails++; $display("[TB] FAIL drop4_pulses got=%0d exp=1", pulses); end
    checks++; if (led0 !== 4'b0010) begin fails++; $display("[TB] FAIL drop4_led got=%h exp=2", led0); end
    checks++; if (cnt0 !== 4'd3) begin fails++; $display("[TB] FAIL drop4_count got=%0d exp=3", cnt0); end
  endtask

  task automatic test_simultaneous_wrap;
    logic [3:0] exp_pulse;
    sw0 = 4'hF; tick(10);
    sw0 = 4'h0; tick(10);
    sw0 = 4'hF; tick(10);
    sw0 = 4'h0; tick(10);
    sw0 = 4'hF; tick(10);
    sw0 = 4'b1000; tick(10);
    checks++; if (cnt0 !== 4'd14) begin fails++; $display("[TB] FAIL preload_count got=%0d exp=14", cnt0); end
    checks++; if (led0 !== 4'b0101) begin fails++; $display("[TB] FAIL preload_led got=%h exp=5", led0); end
    sw0 = 4'hF; tick(10);
    sw0 = 4'h0;
    for (int e = 0; e < 10; e++) begin
      tick(1);
      exp_pulse = (e == 6) ? 4'hF : 4'h0;
      checks++; if (pulse0 !== exp_pulse) begin fails++; $display("[TB] FAIL simul_pulse edge=%0d got=%h exp=%h", e, pulse0, exp_pulse); end
      if (e == 6) begin
        checks++; if (cnt0 !== 4'd2) begin fails++; $display("[TB] FAIL wrap_count got=%0d exp=2", cnt0); end
        checks++; if (led0 !== 4'b1010) begin fails++; $display("[TB] FAIL simul_led got=%h exp=a", led0); end
      end
    end
  endtask

  task automatic test_clear_priority;
    sw0 = 4'hF; tick(10);
    sw0 = 4'h0; tick(10);
    sw0 = 4'b0100; tick(10);
    checks++; if (led0 !== 4'b0101) begin fails++; $display("[TB] FAIL clear_pre_led got=%h exp=5", led0); end
    sw0 = 4'h0;
    for (int e = 0; e < 7; e++) begin
      tick(1);
      if (e == 5) clr0 = 1'b1;
      if (e == 6) begin
        checks++; if (led0 !== 4'h0) begin fails++; $display("[TB] FAIL clear_led got=%h exp=0", led0); end
        checks++; if (pulse0 !== 4'b0100) begin fails++; $display("[TB] FAIL clear_pulse got=%h exp=4", pulse0); end
        checks++; if (cnt0 !== 4'd7) begin fails++; $display("[TB] FAIL clear_count got=%0d exp=7", cnt0); end
        clr0 = 1'b0;
      end
    end
    tick(4);
    checks++; if (led0 !== 4'h0) begin fails++; $display("[TB] FAIL clear_hold_led got=%h exp=0", led0); end
  endtask

  task automatic test_both_edges;
    int pulses;
    pulses = 0;
    sw2 = 4'b1000;
    for (int e = 0; e < 10; e++) begin
      tick(1);
      if (pulse2[3]) pulses++;
      if (e == 6) begin
        checks++; if (pulse2 !== 4'b1000) begin fails++; $display("[TB] FAIL both_rise_pulse got=%h exp=8", pulse2); end
        checks++; if (led2 !== 4'b1000) begin fails++; $display("[TB] FAIL both_rise_led got=%h exp=8", led2); end
      end
    end
    sw2 = 4'h0;
    for (int e = 0; e < 10; e++) begin
      tick(1);
      if (pulse2[3]) pulses++;
    end
    checks++; if (pulses !== 2) begin fails++; $display("[TB] FAIL both_pulses got=%0d exp=2", pulses); end
    checks++; if (led2 !== 4'h0) begin fails++; $display("[TB] FAIL both_led got=%h exp=0", led2); end
    checks++; if (cnt2 !== 4'd2) begin fails++; $display("[TB] FAIL both_count got=%0d exp=2", cnt2); end
  endtask

  task automatic test_mid_debounce_reset;
    sw2 = 4'b1000; tick(2);
    rst2 = 1'b1; sw2 = 4'h0; tick(2);
    checks++; if (cnt2 !== 4'd0) begin fails++; $display("[TB] FAIL midrst_count got=%0d exp=0", cnt2); end
    checks++; if (led2 !== 4'h0) begin fails++; $display("[TB] FAIL midrst_led got=%h exp=0", led2); end
    rst2 = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick(1);
      checks++; if (pulse2 !== 4'h0) begin fails++; $display("[TB] FAIL midrst_pulse cyc=%0d got=%h exp=0", c, pulse2); end
    end
    checks++; if (cnt2 !== 4'd0) begin fails++; $display("[TB] FAIL midrst_final_count got=%0d exp=0", cnt2); end
  endtask

  initial begin
    test_reset();
    test_falling_toggle();
    test_bounce();
    test_simultaneous_wrap();
    test_clear_priority();
    test_both_edges();
    test_mid_debounce_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired before end of test");
    $fatal(1, "[TB] timeout");
  end

endmodule
